// File: rtl/tdm_pkg.sv
// tdm_pkg: shared sizing helpers for the TDM receive path
package tdm_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int slot_w(input int n);
    return (n > 2) ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: mod-CHANNELS slot index with increment, load-to-1 and sync clear
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int CHANNELS = 2,
  localparam int SLOT_W = slot_w(CHANNELS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              inc,
  input  logic              load,
  output logic [SLOT_W-1:0] sel,
  output logic              last
);
  assign last = sel == SLOT_W'(CHANNELS - 1);
  always_ff @(posedge clk)
    sel <= clr ? '0 : load ? SLOT_W'(1) : inc ? (last ? '0 : sel + SLOT_W'(1)) : sel;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: TDM receive demultiplexer rebuilding CHANNELS parallel words from a slot stream
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH = 1,
  localparam int SLOT_W = slot_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [WIDTH-1:0]          din,
  input  logic                      sync,
  output logic [SLOT_W-1:0]         sel,
  output logic [CHANNELS*WIDTH-1:0] D,
  output logic                      valid,
  output logic                      locked,
  output logic                      sync_err
);
  logic                          last;
  logic                          done;
  logic [SLOT_W-1:0]             idx;
  logic [(CHANNELS-1)*WIDTH-1:0] stg;
  // sync always restarts at slot 0 so the counter reloads to 1 regardless of lock state
  tdm_slot_counter #(.CHANNELS(CHANNELS)) u_cnt (
    .clk (clk),
    .clr (rst),
    .inc (en & locked & ~sync),
    .load(en & sync),
    .sel (sel),
    .last(last)
  );
  always_comb begin
    done = en & locked & ~sync & last;
    idx = sync ? '0 : sel;
  end
  // the last slot bypasses staging and lands in D directly
  always_ff @(posedge clk) begin
    if (rst) begin
      D <= '0;
      valid <= 1'b0;
      locked <= 1'b0;
      sync_err <= 1'b0;
      stg <= '0;
    end else begin
      valid <= done;
      sync_err <= en & sync & (sel != '0);
      locked <= locked | (en & sync);
      if (done) D <= {din, stg};
      for (int k = 0; k < CHANNELS - 1; k++)
        if (en & (sync | locked) & (idx == SLOT_W'(k))) stg[k*WIDTH +: WIDTH] <= din;
    end
  end
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: randomized and directed check of two tdm_demux configurations against a frame model
module tb_tdm_demux;
  logic clk = 0;
  logic rst, en, sync, din2;
  logic [7:0] din4;
  logic sel2, valid2, locked2, err2, valid4, locked4, err4;
  logic [1:0] sel4, d2;
  logic [31:0] d4;
  int n_chk = 0, n_fail = 0;
  int m_cnt [2];
  logic m_locked [2], m_valid [2], m_err [2];
  logic [31:0] m_d [2];
  logic [7:0] m_stage [2][4];

  always #5 clk = ~clk;

  tdm_demux #(.CHANNELS(2), .WIDTH(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din2), .sync(sync),
    .sel(sel2), .D(d2), .valid(valid2), .locked(locked2), .sync_err(err2)
  );
  tdm_demux #(.CHANNELS(4), .WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .en(en), .din(din4), .sync(sync),
    .sel(sel4), .D(d4), .valid(valid4), .locked(locked4), .sync_err(err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // frame-level model: collect samples after a sync, emit a packed word once CHANNELS are in
  task automatic model(input int ch, input logic r, input logic e, input logic s, input logic [7:0] v);
    int c, w;
    c = ch ? 4 : 2;
    w = ch ? 8 : 1;
    if (r) begin
      m_cnt[ch] = 0;
      m_locked[ch] = 0;
      m_valid[ch] = 0;
      m_err[ch] = 0;
      m_d[ch] = 0;
      for (int k = 0; k < 4; k++) m_stage[ch][k] = 0;
      return;
    end
    m_valid[ch] = 0;
    m_err[ch] = 0;
    if (!e) return;
    if (s) begin
      m_err[ch] = m_cnt[ch] != 0;
      m_stage[ch][0] = v;
      m_cnt[ch] = 1;
      m_locked[ch] = 1;
    end else if (m_locked[ch]) begin
      if (m_cnt[ch] == c - 1) begin
        m_d[ch] = 0;
        for (int k = 0; k < c - 1; k++) m_d[ch] = m_d[ch] | (32'(m_stage[ch][k]) << (k * w));
        m_d[ch] = m_d[ch] | (32'(v) << ((c - 1) * w));
        m_valid[ch] = 1;
        m_cnt[ch] = 0;
      end else begin
        m_stage[ch][m_cnt[ch]] = v;
        m_cnt[ch]++;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic a, input logic [7:0] b);
    rst = r; en = e; sync = s; din2 = a; din4 = b;
    @(posedge clk);
    model(0, r, e, s, {7'b0, a});
    model(1, r, e, s, b);
    #1;
    check("sel2", 32'(sel2), m_cnt[0]);
    check("d2", 32'(d2), m_d[0]);
    check("valid2", 32'(valid2), 32'(m_valid[0]));
    check("locked2", 32'(locked2), 32'(m_locked[0]));
    check("err2", 32'(err2), 32'(m_err[0]));
    check("sel4", 32'(sel4), m_cnt[1]);
    check("d4", d4, m_d[1]);
    check("valid4", 32'(valid4), 32'(m_valid[1]));
    check("locked4", 32'(locked4), 32'(m_locked[1]));
    check("err4", 32'(err4), 32'(m_err[1]));
  endtask

  initial begin
    rst = 1; en = 0; sync = 0; din2 = 0; din4 = 0;
    step(1, 1, 0, 1, 8'hFF);
    step(1, 1, 0, 1, 8'hFF);
    check("t1_d", 32'(d2), 0);
    check("t1_locked", 32'(locked2), 0);
    step(0, 1, 1, 1, 8'h00);
    check("t2_sel1", 32'(sel2), 1);
    step(0, 1, 0, 0, 8'h00);
    check("t2_d", 32'(d2), 32'h1);
    check("t2_valid", 32'(valid2), 1);
    check("t2_sel0", 32'(sel2), 0);
    step(0, 0, 0, 0, 8'h00);
    check("t2_valid_end", 32'(valid2), 0);
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 8'h11);
    check("t3_locked", 32'(locked2), 0);
    check("t3_d", 32'(d2), 0);
    step(0, 1, 1, 0, 8'h00);
    step(0, 1, 1, 1, 8'h00);
    check("t4_err", 32'(err2), 1);
    check("t4_sel", 32'(sel2), 1);
    check("t4_d", 32'(d2), 0);
    step(0, 1, 0, 1, 8'h00);
    check("t4_d11", 32'(d2), 32'h3);
    check("t4_valid", 32'(valid2), 1);
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 1, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 1, 1, 8'h00);
    check("t5_hold_sel", 32'(sel2), 1);
    step(0, 1, 0, 1, 8'h00);
    check("t5_d", 32'(d2), 32'h2);
    check("t5_valid", 32'(valid2), 1);
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 1, 0, 8'hA1);
    step(0, 1, 0, 0, 8'hB2);
    step(0, 1, 0, 0, 8'hC3);
    step(0, 1, 0, 0, 8'hD4);
    check("t6_d", d4, 32'hD4C3B2A1);
    check("t6_valid", 32'(valid4), 1);
    step(0, 1, 1, 0, 8'hA1);
    step(0, 1, 0, 0, 8'hB2);
    step(1, 0, 0, 0, 8'h00);
    check("t6_unlocked", 32'(locked4), 0);
    step(0, 1, 0, 0, 8'hC3);
    step(0, 1, 0, 0, 8'hD4);
    check("t6_novalid", 32'(valid4), 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) < 2, $urandom_range(99) < 70, $urandom_range(99) < 10,
           1'($urandom), 8'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
